// File: rtl/rx_pfc_pause_if.sv
// Receive parser stream feeding the MAC control (PAUSE/PFC) decoder.
interface rx_pfc_pause_if;
    logic        in_par_en;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_err;

    modport master (output in_par_en, in_data, in_valid, in_sop, in_eop, in_err);
    modport slave  (input  in_par_en, in_data, in_valid, in_sop, in_eop, in_err);
endinterface

// File: rtl/rx_pfc_pause.sv
// Receive-side 802.3x PAUSE / 802.1Qbb PFC parser with one pause timer per class.
// Optional destination-address check is enabled with `define RX_PFC_DA_CHECK_EN.
module rx_pfc_pause #(
    parameter int NUM_CLASS       = 8,
    parameter int BYTES_PER_CYCLE = 4,
    parameter int CNT_W           = 16
) (
    input  logic                 in_clk,
    input  logic                 rst,
    input  logic [31:0]          up_data_rx_ctrl,
    rx_pfc_pause_if.slave        stream,
    output logic [NUM_CLASS-1:0] pause_on,
    output logic [CNT_W-1:0]     pause_frame_cnt,
    output logic [CNT_W-1:0]     pfc_frame_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, PAUSE, PFC, SKIP} state_t;

    localparam logic [21:0] STEP = 22'(BYTES_PER_CYCLE);

    state_t               state_q;
    logic [3:0]           wcnt_q;
    logic [3:0]           wIdx;
    logic [15:0]          shTime_q [NUM_CLASS];
    logic [15:0]          shTime_d [NUM_CLASS];
    logic [NUM_CLASS-1:0] shValid_q, shValid_d;
    logic [21:0]          timer_q  [NUM_CLASS];
    logic [NUM_CLASS-1:0] pause_on_q;
    logic [CNT_W-1:0]     pause_cnt_q, pfc_cnt_q;
    logic                 beat, eopBeat, daOk, pauseHit, pfcHit;
    logic                 commitPause, commitPfc;
    logic                 unusedCtrl;

    assign unusedCtrl = ^{up_data_rx_ctrl[31:7], up_data_rx_ctrl[4:0]};

    assign beat    = stream.in_par_en && stream.in_valid;
    assign eopBeat = beat && stream.in_eop && !stream.in_sop;
    // Index of the word on the bus this cycle: SOP is always word 0.
    assign wIdx    = stream.in_sop ? 4'd0 : ((wcnt_q == 4'd15) ? 4'd15 : wcnt_q + 4'd1);

`ifdef RX_PFC_DA_CHECK_EN
    logic daOk_q;

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            daOk_q <= 1'b0;
        end else if (beat) begin
            if (stream.in_sop)
                daOk_q <= (stream.in_data == 32'h0180C200);
            else if (state_q == HDR && wIdx == 4'd1)
                daOk_q <= daOk_q && (stream.in_data[31:16] == 16'h0001);
        end
    end

    assign daOk = daOk_q;
`else
    assign daOk = 1'b1;
`endif

    assign pauseHit = daOk && up_data_rx_ctrl[5] && (stream.in_data == 32'h88080001);
    assign pfcHit   = daOk && up_data_rx_ctrl[6] && (stream.in_data == 32'h88080101);

    assign commitPause = eopBeat && !stream.in_err && state_q == PAUSE && wIdx >= 4'd4;
    assign commitPfc   = eopBeat && !stream.in_err && state_q == PFC   && wIdx >= 4'd8;

    // Shadow capture; the EOP word may carry the last field, so commit uses the _d view.
    always_comb begin
        shTime_d  = shTime_q;
        shValid_d = shValid_q;
        if (beat) begin
            if (stream.in_sop) begin
                for (int i = 0; i < NUM_CLASS; i++) shTime_d[i] = 16'd0;
                shValid_d = '0;
            end else if (state_q == PAUSE && wIdx == 4'd4) begin
                for (int i = 0; i < NUM_CLASS; i++) shTime_d[i] = stream.in_data[31:16];
                shValid_d = '1;
            end else if (state_q == PFC) begin
                for (int i = 0; i < NUM_CLASS; i++) begin
                    if (wIdx == 4'd4)
                        shValid_d[i] = stream.in_data[16 + i];
                    if ((i % 2) == 0 && wIdx == 4'((i + 8) / 2))
                        shTime_d[i] = stream.in_data[15:0];
                    if ((i % 2) == 1 && wIdx == 4'((i + 9) / 2))
                        shTime_d[i] = stream.in_data[31:16];
                end
            end
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
        end else if (beat) begin
            wcnt_q <= wIdx;
            if (stream.in_sop)
                state_q <= stream.in_eop ? IDLE : HDR;
            else if (stream.in_eop)
                state_q <= IDLE;
            else if (state_q == HDR && wIdx == 4'd3)
                state_q <= pauseHit ? PAUSE : (pfcHit ? PFC : SKIP);
        end
    end

    // Commit wins over decrement; classes not loaded by this frame keep running.
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                shTime_q[i] <= 16'd0;
                timer_q[i]  <= 22'd0;
            end
            shValid_q  <= '0;
            pause_on_q <= '0;
        end else begin
            shTime_q  <= shTime_d;
            shValid_q <= shValid_d;
            for (int i = 0; i < NUM_CLASS; i++) begin
                pause_on_q[i] <= (timer_q[i] != 22'd0);
                if ((commitPause || commitPfc) && shValid_d[i])
                    timer_q[i] <= {shTime_d[i], 6'd0};
                else if (stream.in_par_en)
                    timer_q[i] <= (timer_q[i] > STEP) ? timer_q[i] - STEP : 22'd0;
            end
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            pause_cnt_q <= '0;
            pfc_cnt_q   <= '0;
        end else begin
            if (commitPause && pause_cnt_q != '1)
                pause_cnt_q <= pause_cnt_q + 1'b1;
            if (commitPfc && pfc_cnt_q != '1)
                pfc_cnt_q <= pfc_cnt_q + 1'b1;
        end
    end

    assign pause_on        = pause_on_q;
    assign pause_frame_cnt = pause_cnt_q;
    assign pfc_frame_cnt   = pfc_cnt_q;
endmodule

// File: tb/tb_rx_pfc_pause.sv
// Directed bench for rx_pfc_pause: frames are driven on negedges, outputs sampled on negedges.
module tb_rx_pfc_pause;
    localparam int NUM_CLASS = 8;

    logic                 in_clk = 1'b0;
    logic                 rst;
    logic [31:0]          ctrl;
    logic [NUM_CLASS-1:0] pauseOn;
    logic [15:0]          pauseCnt, pfcCnt;
    logic [31:0]          frameBuf [16];
    int                   errCount   = 0;
    int                   checkCount = 0;

    rx_pfc_pause_if bus();

    rx_pfc_pause #(.NUM_CLASS(NUM_CLASS), .BYTES_PER_CYCLE(4), .CNT_W(16)) dut (
        .in_clk          (in_clk),
        .rst             (rst),
        .up_data_rx_ctrl (ctrl),
        .stream          (bus),
        .pause_on        (pauseOn),
        .pause_frame_cnt (pauseCnt),
        .pfc_frame_cnt   (pfcCnt)
    );

    always #5 in_clk = ~in_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadPause(input logic [15:0] quanta);
        frameBuf[0] = 32'h0180C200;
        frameBuf[1] = 32'h00010011;
        frameBuf[2] = 32'h22334455;
        frameBuf[3] = 32'h88080001;
        frameBuf[4] = {quanta, 16'h0000};
    endtask

    task automatic loadPfc(input logic [7:0] cev, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2);
        frameBuf[0] = 32'h0180C200;
        frameBuf[1] = 32'h00010011;
        frameBuf[2] = 32'h22334455;
        frameBuf[3] = 32'h88080101;
        frameBuf[4] = {8'h00, cev, t0};
        frameBuf[5] = {t1, t2};
        frameBuf[6] = 32'h0;
        frameBuf[7] = 32'h0;
        frameBuf[8] = 32'h0;
    endtask

    // Called on a negedge; returns on the negedge following the last word's clock edge.
    task automatic applyStimulus(input int len, input bit withEop, input bit err);
        for (int w = 0; w < len; w++) begin
            bus.in_par_en = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = frameBuf[w];
            bus.in_sop    = (w == 0);
            bus.in_eop    = withEop && (w == len - 1);
            bus.in_err    = err && (w == len - 1);
            @(posedge in_clk);
            @(negedge in_clk);
        end
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_err   = 1'b0;
        bus.in_data  = 32'h0;
    endtask

    task automatic skipCycles(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    // in_par_en high on one clock in ten, counted from the cycle after the commit.
    task automatic runGated(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            bus.in_par_en = ((c % 10) == 0);
            @(negedge in_clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ctrl          = 32'h00000060;
        bus.in_par_en = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.in_err    = 1'b0;
        for (int i = 0; i < 16; i++) frameBuf[i] = 32'h0;
        skipCycles(3);
        checkOutput("reset_pause_on", 32'(pauseOn), 32'h0);
        checkOutput("reset_pause_cnt", 32'(pauseCnt), 32'h0);
        checkOutput("reset_pfc_cnt", 32'(pfcCnt), 32'h0);
        rst = 1'b0;
        skipCycles(2);

        // PAUSE, 2 quanta = 128 byte-times = 32 enabled cycles
        loadPause(16'h0002);
        applyStimulus(5, 1'b1, 1'b0);
        checkOutput("pause_at_eop", 32'(pauseOn), 32'h00);
        skipCycles(1);
        checkOutput("pause_on_all", 32'(pauseOn), 32'hFF);
        checkOutput("pause_cnt_1", 32'(pauseCnt), 32'd1);
        checkOutput("pfc_cnt_0", 32'(pfcCnt), 32'd0);
        skipCycles(31);
        checkOutput("pause_hold_32", 32'(pauseOn), 32'hFF);
        skipCycles(1);
        checkOutput("pause_expire_33", 32'(pauseOn), 32'h00);

        // PFC cev=0x05: class0 64 byte-times, class2 192; class1 time ignored
        loadPfc(8'h05, 16'd1, 16'h00FF, 16'd3);
        applyStimulus(9, 1'b1, 1'b0);
        checkOutput("pfc_at_eop", 32'(pauseOn), 32'h00);
        skipCycles(1);
        checkOutput("pfc_on", 32'(pauseOn), 32'h05);
        checkOutput("pfc_cnt_1", 32'(pfcCnt), 32'd1);
        checkOutput("pause_cnt_still_1", 32'(pauseCnt), 32'd1);
        skipCycles(15);
        checkOutput("pfc_c0_hold", 32'(pauseOn), 32'h05);
        skipCycles(1);
        checkOutput("pfc_c0_drop", 32'(pauseOn), 32'h04);
        skipCycles(31);
        checkOutput("pfc_c2_hold", 32'(pauseOn), 32'h04);
        skipCycles(1);
        checkOutput("pfc_c2_drop", 32'(pauseOn), 32'h00);

        // XON on class 0 while class 2 keeps counting
        loadPfc(8'h05, 16'd5, 16'd0, 16'd3);
        applyStimulus(9, 1'b1, 1'b0);
        loadPfc(8'h01, 16'd0, 16'd0, 16'd0);
        applyStimulus(9, 1'b1, 1'b0);
        checkOutput("xon_at_eop", 32'(pauseOn), 32'h05);
        skipCycles(1);
        checkOutput("xon_c0_clear", 32'(pauseOn), 32'h04);
        checkOutput("xon_pfc_cnt", 32'(pfcCnt), 32'd3);
        skipCycles(38);
        checkOutput("xon_c2_hold", 32'(pauseOn), 32'h04);
        skipCycles(1);
        checkOutput("xon_c2_drop", 32'(pauseOn), 32'h00);

        // Rejected frames: error at EOP, EOP at word 3, PAUSE disabled
        loadPause(16'h0010);
        applyStimulus(5, 1'b1, 1'b1);
        skipCycles(1);
        checkOutput("err_no_pause", 32'(pauseOn), 32'h00);
        applyStimulus(4, 1'b1, 1'b0);
        skipCycles(1);
        checkOutput("short_no_pause", 32'(pauseOn), 32'h00);
        ctrl = 32'h00000040;
        applyStimulus(5, 1'b1, 1'b0);
        skipCycles(1);
        checkOutput("disabled_no_pause", 32'(pauseOn), 32'h00);
        checkOutput("rejected_cnt", 32'(pauseCnt), 32'd1);
        ctrl = 32'h00000060;

        // PFC frame cut by a new SOP, then a good PAUSE of 1 quanta
        loadPfc(8'h05, 16'd7, 16'd0, 16'd9);
        applyStimulus(6, 1'b0, 1'b0);
        loadPause(16'h0001);
        applyStimulus(5, 1'b1, 1'b0);
        skipCycles(1);
        checkOutput("resync_on", 32'(pauseOn), 32'hFF);
        checkOutput("resync_pause_cnt", 32'(pauseCnt), 32'd2);
        checkOutput("resync_pfc_cnt", 32'(pfcCnt), 32'd3);
        skipCycles(15);
        checkOutput("resync_hold", 32'(pauseOn), 32'hFF);
        skipCycles(1);
        checkOutput("resync_drop", 32'(pauseOn), 32'h00);

        // Gated decrement: 16 enabled cycles spread over 160 clocks
        applyStimulus(5, 1'b1, 1'b0);
        runGated(1, 160);
        checkOutput("gated_hold_160", 32'(pauseOn), 32'hFF);
        checkOutput("gated_pause_cnt", 32'(pauseCnt), 32'd3);
        runGated(161, 161);
        checkOutput("gated_drop_161", 32'(pauseOn), 32'h00);

        // Asynchronous reset in the middle of a count
        applyStimulus(5, 1'b1, 1'b0);
        runGated(1, 50);
        checkOutput("pre_reset_on", 32'(pauseOn), 32'hFF);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_on", 32'(pauseOn), 32'h00);
        checkOutput("async_reset_cnt", 32'(pauseCnt), 32'd0);
        skipCycles(2);
        rst = 1'b0;
        bus.in_par_en = 1'b1;
        skipCycles(2);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/rx_pfc_pause.md
Name: rx_pfc_pause

Overview:
Receive-side MAC control parser. It decodes IEEE 802.3x PAUSE frames (opcode 0x0001) and 802.1Qbb priority flow control (PFC) frames (opcode 0x0101) from the 32-bit parser stream, and keeps one pause timer per traffic class. Timers are committed only at a clean end-of-frame. The block sits beside the rx parser and drives per-class pause_on to the tx scheduler. It is the parametrised, multi-class successor of the single-timer rx pause block.

Parameters:
NUM_CLASS, 8, number of priority classes/timers (1..8); classes >= NUM_CLASS are ignored.
BYTES_PER_CYCLE, 4, byte-times elapsed per in_par_en cycle; this is the timer decrement step.
CNT_W, 16, width of the frame statistics counters.

Ports:
in_clk  in  1  clock
rst  in  1  reset
up_data_rx_ctrl  in  32  bit5 = PAUSE enable, bit6 = PFC enable; other bits ignored
in_par_en  in  1  parallel enable; all stream sampling and timer decrement are qualified by it
in_data  in  32  frame data, first byte in [31:24]
in_valid  in  1  in_data valid
in_sop  in  1  start of packet
in_eop  in  1  end of packet
in_err  in  1  frame error flag, sampled with in_eop
pause_on  out  NUM_CLASS  per-class transmit hold
pause_frame_cnt  out  CNT_W  accepted 802.3x frames
pfc_frame_cnt  out  CNT_W  accepted PFC frames

Behaviour:
- Reset is asynchronous and active-high (rst); the clock is in_clk. During reset: all timers = 0, shadows = 0, pause_on = 0, both counters = 0, FSM = IDLE.
- A cycle is a "beat" when in_par_en && in_valid.
- Word counter wcnt (4 bit): cleared to 0 on an SOP beat, +1 on each later beat, saturates at 15.
- Word map (untagged frames only; tagged control frames are not decoded):
  - w0..w2: DA/SA.
  - w3: {ethertype, opcode}.
  - w4: PAUSE uses [31:16] as the time; PFC uses [31:16] as the class-enable vector (bits 15:8 ignored) and [15:0] as time0.
  - w5: {time1, time2}. w6: {time3, time4}. w7: {time5, time6}. w8[31:16]: time7.
- FSM, advanced on beats only:
  - IDLE: an SOP beat moves to HDR.
  - HDR: at w3, 0x88080001 with ctrl bit5 set moves to PAUSE; 0x88080101 with ctrl bit6 set moves to PFC; any other value moves to SKIP.
  - PAUSE / PFC: capture the fields into a per-class shadow time and shadow valid vector.
  - PAUSE loads every class with the same time.
  - PFC loads class i only when cev[i] = 1.
  - At an EOP beat: commit when in_err = 0 and the minimum length is met (wcnt >= 4 for PAUSE, wcnt >= 8 for PFC); otherwise discard. Either way, go to IDLE.
  - SKIP: wait for EOP, then go to IDLE.
  - An SOP beat in any state discards the shadows and restarts HDR.
- Timers: NUM_CLASS x 22 bit, in byte-time units.
  - Commit loads timer[i] = time_i * 64 (1 quanta = 64 byte-times) for each valid class.
  - Commit has priority over decrement in the same cycle.
  - Otherwise, on in_par_en, timer[i] -= BYTES_PER_CYCLE, saturating at 0 (no wrap).
  - A committed time of 0 clears the class immediately (XON).
  - Non-enabled PFC classes keep their running value.
- pause_on[i] is registered: pause_on[i] <= (timer[i] != 0). Latency is 1 in_clk after commit or expiry.
- Clearing ctrl bit5 or bit6 mid-frame affects only the next w3 decode. Running timers keep counting.
- Counters: +1 on each commit of the respective type; saturate at all-ones.

Optional Feature:
- Macro RX_PFC_DA_CHECK_EN.
- Defined: w0 must equal 0x0180C200 and w1[31:16] must equal 0x0001. On mismatch the frame goes to SKIP and no counter increments.
- Undefined: DA is not checked; any DA with a matching ethertype/opcode is accepted.

Test Plan:
- PAUSE frame, time 0x0002, ctrl bit5 = 1, in_par_en = 1 -> all pause_on = 0xFF one cycle after EOP; deasserts after 32 cycles (128/4); pause_frame_cnt = 1.
- PFC frame, cev = 0x05, time0 = 1, time2 = 3 -> pause_on = 0x05; bit0 drops after 16 cycles, bit2 after 48 cycles; pfc_frame_cnt = 1; other classes stay 0.
- PFC frame with cev = 0x01, time0 = 0, while class 0 is paused -> pause_on[0] clears one cycle after EOP; class 2 keeps counting.
- PAUSE frame with in_err = 1 at EOP, or EOP at wcnt = 3 -> no timer change, counter unchanged.
- New SOP mid-PFC frame, followed by a good PAUSE frame (time 1) -> only the PAUSE values are applied; pfc_frame_cnt unchanged.
- in_par_en toggling 1-in-10 with PAUSE time 1 -> expiry after 16 enabled cycles (160 clocks); assert rst mid-count -> pause_on = 0 immediately.
